// File: rtl/stage_6_leaf_unit_if.sv
// Request/response bundle between the stage-5 registers, the leaf stage and its consumers.
interface stage_6_leaf_unit_if #(
  parameter int unsigned NODE_W = 8,
  parameter int unsigned TAG_W  = 12
);
  logic              ena;
  logic              valid_in;
  logic [1:0]        op_in;
  logic [TAG_W-1:0]  incoming_tag_in;
  logic [NODE_W-1:0] matching_tag_in;
  logic [NODE_W-1:0] matching_tag_bak_in;
  logic              ready;
  logic              result_valid;
  logic [TAG_W-1:0]  result_tag;
  logic              result_hit;
  logic              result_from_bak;
  logic              node_update_valid;
  logic [NODE_W-1:0] node_update_addr;
  logic              node_update_nonempty;

  modport master (
    output ena, valid_in, op_in, incoming_tag_in, matching_tag_in, matching_tag_bak_in,
    input  ready, result_valid, result_tag, result_hit, result_from_bak,
           node_update_valid, node_update_addr, node_update_nonempty
  );

  modport slave (
    input  ena, valid_in, op_in, incoming_tag_in, matching_tag_in, matching_tag_bak_in,
    output ready, result_valid, result_tag, result_hit, result_from_bak,
           node_update_valid, node_update_addr, node_update_nonempty
  );
endinterface

// File: rtl/stage_6_leaf_unit.sv
// Leaf stage of the multibit-tree tag sorter: leaf bitmap RAM with insert and
// extract-min, two-stage pipeline (read, then modify/write) with write-to-read forwarding.
module stage_6_leaf_unit #(
  parameter int unsigned NODE_W = 8,
  parameter int unsigned LEAF_W = 4,
  parameter int unsigned TAG_W  = 12
) (
  input logic                clk,
  input logic                rst,
  stage_6_leaf_unit_if.slave bus
);
  localparam int unsigned NODES  = 1 << NODE_W;
  localparam int unsigned WORD_W = 1 << LEAF_W;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            state;
  logic [NODE_W-1:0] init_cnt;
  logic [WORD_W-1:0] mem [NODES];

  logic              s1_valid;
  logic              s1_ins;
  logic [LEAF_W-1:0] s1_leaf;
  logic [NODE_W-1:0] s1_pri;
  logic [NODE_W-1:0] s1_bak;
  logic [WORD_W-1:0] s1_pri_word;
  logic [WORD_W-1:0] s1_bak_word;

  logic              ready;
  logic              result_valid;
  logic [TAG_W-1:0]  result_tag;
  logic              result_hit;
  logic              result_from_bak;
  logic              node_update_valid;
  logic [NODE_W-1:0] node_update_addr;
  logic              node_update_nonempty;

  logic              ins_c, ext_c, accept_c, done_c;
  logic [NODE_W-1:0] rd_pri_c, rd_bak_c;
  logic [WORD_W-1:0] fwd_pri_c, fwd_bak_c;
  logic [LEAF_W-1:0] pri_low_c, bak_low_c;
  logic              wr_en_c, hit_c, from_bak_c;
  logic [NODE_W-1:0] wr_addr_c;
  logic [WORD_W-1:0] wr_data_c;
  logic [TAG_W-1:0]  tag_c;
  logic              mem_we_c;
  logic [NODE_W-1:0] mem_waddr_c;
  logic [WORD_W-1:0] mem_wdata_c;

  // Request decode and S1 read addresses
  always_comb begin
    ins_c    = (bus.op_in == 2'b01);
    ext_c    = (bus.op_in == 2'b10);
    accept_c = ready & bus.ena & bus.valid_in & (ins_c | ext_c);
    rd_pri_c = ins_c ? bus.incoming_tag_in[TAG_W-1:LEAF_W] : bus.matching_tag_in;
    rd_bak_c = bus.matching_tag_bak_in;
  end

  // Lowest set bit of each S1 word
  always_comb begin
    pri_low_c = '0;
    bak_low_c = '0;
    for (int i = int'(WORD_W) - 1; i >= 0; i--) begin
      if (s1_pri_word[i]) pri_low_c = LEAF_W'(i);
      if (s1_bak_word[i]) bak_low_c = LEAF_W'(i);
    end
  end

  // S2 modify: insert sets a bit, extract clears the lowest bit of primary, else backup
  always_comb begin
    done_c     = bus.ena & s1_valid;
    wr_en_c    = 1'b0;
    wr_addr_c  = s1_pri;
    wr_data_c  = s1_pri_word;
    hit_c      = 1'b0;
    from_bak_c = 1'b0;
    tag_c      = '0;
    if (s1_ins) begin
      wr_en_c   = done_c;
      wr_data_c = s1_pri_word | (WORD_W'(1) << s1_leaf);
    end else if (s1_pri_word != '0) begin
      wr_en_c   = done_c;
      hit_c     = 1'b1;
      tag_c     = {s1_pri, pri_low_c};
      wr_data_c = s1_pri_word & ~(WORD_W'(1) << pri_low_c);
    end else if ((s1_bak != s1_pri) && (s1_bak_word != '0)) begin
      wr_en_c    = done_c;
      hit_c      = 1'b1;
      from_bak_c = 1'b1;
      wr_addr_c  = s1_bak;
      tag_c      = {s1_bak, bak_low_c};
      wr_data_c  = s1_bak_word & ~(WORD_W'(1) << bak_low_c);
    end
  end

  // A word written by S2 on this edge supersedes the stale RAM read
  always_comb begin
    fwd_pri_c = (wr_en_c && (wr_addr_c == rd_pri_c)) ? wr_data_c : mem[rd_pri_c];
    fwd_bak_c = (wr_en_c && (wr_addr_c == rd_bak_c)) ? wr_data_c : mem[rd_bak_c];
  end

  always_comb begin
    mem_we_c    = (state == ST_INIT) | wr_en_c;
    mem_waddr_c = (state == ST_INIT) ? init_cnt : wr_addr_c;
    mem_wdata_c = (state == ST_INIT) ? '0 : wr_data_c;
  end

  always_ff @(posedge clk) begin
    if (mem_we_c) mem[mem_waddr_c] <= mem_wdata_c;
  end

  // Control FSM, pipeline registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= ST_INIT;
      init_cnt             <= '0;
      ready                <= 1'b0;
      s1_valid             <= 1'b0;
      s1_ins               <= 1'b0;
      s1_leaf              <= '0;
      s1_pri               <= '0;
      s1_bak               <= '0;
      s1_pri_word          <= '0;
      s1_bak_word          <= '0;
      result_valid         <= 1'b0;
      result_tag           <= '0;
      result_hit           <= 1'b0;
      result_from_bak      <= 1'b0;
      node_update_valid    <= 1'b0;
      node_update_addr     <= '0;
      node_update_nonempty <= 1'b0;
    end else begin
      if (state == ST_INIT) begin
        init_cnt <= init_cnt + NODE_W'(1);
        if (init_cnt == NODE_W'(NODES - 1)) begin
          state <= ST_RUN;
          ready <= 1'b1;
        end
      end
      if (bus.ena) begin
        s1_valid <= accept_c;
        if (accept_c) begin
          s1_ins      <= ins_c;
          s1_leaf     <= bus.incoming_tag_in[LEAF_W-1:0];
          s1_pri      <= rd_pri_c;
          s1_bak      <= rd_bak_c;
          s1_pri_word <= fwd_pri_c;
          s1_bak_word <= fwd_bak_c;
        end
        result_valid      <= done_c & ~s1_ins;
        node_update_valid <= wr_en_c;
        if (done_c && !s1_ins) begin
          result_tag      <= tag_c;
          result_hit      <= hit_c;
          result_from_bak <= from_bak_c;
        end
        if (wr_en_c) begin
          node_update_addr     <= wr_addr_c;
          node_update_nonempty <= |wr_data_c;
        end
      end
    end
  end

  assign bus.ready                = ready;
  assign bus.result_valid         = result_valid;
  assign bus.result_tag           = result_tag;
  assign bus.result_hit           = result_hit;
  assign bus.result_from_bak      = result_from_bak;
  assign bus.node_update_valid    = node_update_valid;
  assign bus.node_update_addr     = node_update_addr;
  assign bus.node_update_nonempty = node_update_nonempty;
endmodule

// File: tb/tb_stage_6_leaf_unit.sv
// Scoreboard bench for the leaf stage: a bitmap-array reference model predicts each
// completion, a monitor pops and compares whenever the stage reports one.
module tb_stage_6_leaf_unit;
  localparam int unsigned NODE_W = 8;
  localparam int unsigned LEAF_W = 4;
  localparam int unsigned TAG_W  = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stage_6_leaf_unit_if #(.NODE_W(NODE_W), .TAG_W(TAG_W)) bus ();

  stage_6_leaf_unit #(.NODE_W(NODE_W), .LEAF_W(LEAF_W), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        ext;
    logic [11:0] tag;
    logic        hit;
    logic        bak;
    logic        uv;
    logic [7:0]  addr;
    logic        ne;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model [256];
  int          total = 0;
  int          bad   = 0;
  logic        last_live = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_clear();
    for (int n = 0; n < 256; n++) model[n] = 16'h0;
    sb.delete();
  endtask

  task automatic push_insert(input logic [11:0] t);
    exp_t e;
    e = '0;
    model[t[11:4]] = model[t[11:4]] | (16'h1 << t[3:0]);
    e.uv   = 1'b1;
    e.addr = t[11:4];
    e.ne   = 1'b1;
    sb.push_back(e);
  endtask

  // Extract-min: primary node first, then backup; lowest present leaf wins
  task automatic push_extract(input logic [7:0] p, input logic [7:0] b);
    exp_t       e;
    logic [7:0] n;
    int         leaf;
    e    = '0;
    e.ext = 1'b1;
    n    = p;
    leaf = -1;
    if (model[p] != 16'h0) begin
      n = p;
    end else if (model[b] != 16'h0) begin
      n     = b;
      e.bak = 1'b1;
    end
    for (int i = 15; i >= 0; i--) if (model[n][i]) leaf = i;
    if (leaf >= 0) begin
      model[n][leaf] = 1'b0;
      e.tag  = {n, 4'(leaf)};
      e.hit  = 1'b1;
      e.uv   = 1'b1;
      e.addr = n;
      e.ne   = (model[n] != 16'h0);
    end else begin
      e.bak = 1'b0;
    end
    sb.push_back(e);
  endtask

  // One cycle of stimulus; the model sees exactly what the stage accepts at the next edge
  task automatic drive(input logic en, input logic v, input logic [1:0] op,
                       input logic [11:0] t, input logic [7:0] p, input logic [7:0] b);
    bus.ena                 = en;
    bus.valid_in            = v;
    bus.op_in               = op;
    bus.incoming_tag_in     = t;
    bus.matching_tag_in     = p;
    bus.matching_tag_bak_in = b;
    if (en && v) begin
      if (op == 2'b01) push_insert(t);
      else if (op == 2'b10) push_extract(p, b);
    end
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    bus.ena      = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 2'b00, 12'h0, 8'h0, 8'h0);
  endtask

  task automatic do_reset(input int cycles);
    rst          = 1'b1;
    bus.valid_in = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    model_clear();
    check("reset_outputs",
          32'({bus.ready, bus.result_valid, bus.node_update_valid, bus.result_hit,
               bus.result_from_bak, bus.node_update_nonempty, bus.node_update_addr,
               bus.result_tag}), 32'h0);
    rst = 1'b0;
  endtask

  // Ready low for 256 cycles after reset release, high on the 257th; ena toggled meanwhile
  task automatic wait_init();
    logic seen;
    seen = bus.ready;
    for (int i = 0; i < 255; i++) begin
      bus.ena = ((i % 40) < 30);
      @(posedge clk);
      #1;
      seen = seen | bus.ready;
    end
    check("ready_low_during_init", 32'(seen), 32'h0);
    bus.ena = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_init", 32'(bus.ready), 32'h1);
  endtask

  always @(posedge clk) last_live <= bus.ena & ~rst;

  // Monitor: every completing S2 edge consumes one scoreboard entry
  always @(negedge clk) begin
    exp_t e;
    if (last_live && (bus.result_valid || bus.node_update_valid)) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse actual rv=%0b uv=%0b required no pulse at %0t",
                 bus.result_valid, bus.node_update_valid, $time);
      end else begin
        e = sb.pop_front();
        check("result_valid", 32'(bus.result_valid), 32'(e.ext));
        if (e.ext) begin
          check("result_tag", 32'(bus.result_tag), 32'(e.tag));
          check("result_hit", 32'(bus.result_hit), 32'(e.hit));
          check("result_from_bak", 32'(bus.result_from_bak), 32'(e.bak));
        end
        check("node_update_valid", 32'(bus.node_update_valid), 32'(e.uv));
        if (e.uv) begin
          check("node_update_addr", 32'(bus.node_update_addr), 32'(e.addr));
          check("node_update_nonempty", 32'(bus.node_update_nonempty), 32'(e.ne));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  rn, rb;
    logic [11:0] rt;
    bus.ena                 = 1'b1;
    bus.valid_in            = 1'b0;
    bus.op_in               = 2'b00;
    bus.incoming_tag_in     = 12'h0;
    bus.matching_tag_in     = 8'h0;
    bus.matching_tag_bak_in = 8'h0;

    do_reset(2);
    wait_init();

    // Empty RAM: extract misses
    drive(1'b1, 1'b1, 2'b10, 12'h0, 8'h00, 8'h01);
    idle(3);

    // Ordered extraction from one node
    drive(1'b1, 1'b1, 2'b01, 12'h3A7, 8'h0, 8'h0);
    drive(1'b1, 1'b1, 2'b01, 12'h3A2, 8'h0, 8'h0);
    drive(1'b1, 1'b1, 2'b01, 12'h3AF, 8'h0, 8'h0);
    drive(1'b1, 1'b1, 2'b10, 12'h0, 8'h3A, 8'h3B);
    drive(1'b1, 1'b1, 2'b10, 12'h0, 8'h3A, 8'h3B);
    drive(1'b1, 1'b1, 2'b10, 12'h0, 8'h3A, 8'h3B);
    idle(3);

    // Back-to-back insert then extract of the same node
    drive(1'b1, 1'b1, 2'b01, 12'h125, 8'h0, 8'h0);
    drive(1'b1, 1'b1, 2'b10, 12'h0, 8'h12, 8'h13);
    idle(3);

    // Primary empty, backup holds the tag; duplicate insert included
    drive(1'b1, 1'b1, 2'b01, 12'h413, 8'h0, 8'h0);
    drive(1'b1, 1'b1, 2'b01, 12'h413, 8'h0, 8'h0);
    idle(2);
    drive(1'b1, 1'b1, 2'b10, 12'h0, 8'h40, 8'h41);
    drive(1'b1, 1'b1, 2'b10, 12'h0, 8'h40, 8'h40);
    idle(3);

    // Freeze with an extract pending in S1
    drive(1'b1, 1'b1, 2'b01, 12'h555, 8'h0, 8'h0);
    drive(1'b1, 1'b1, 2'b10, 12'h0, 8'h55, 8'h56);
    for (int i = 0; i < 3; i++) begin
      bus.ena = 1'b0;
      @(posedge clk);
      #1;
      check("freeze_update_valid", 32'(bus.node_update_valid), 32'h1);
      check("freeze_update_addr", 32'(bus.node_update_addr), 32'h55);
      check("freeze_result_valid", 32'(bus.result_valid), 32'h0);
    end
    idle(1);
    check("unfreeze_result_valid", 32'(bus.result_valid), 32'h1);
    idle(1);
    check("no_duplicate_pulse", 32'(bus.result_valid), 32'h0);
    idle(2);

    // Reset while an insert is in flight
    drive(1'b1, 1'b1, 2'b01, 12'h0FF, 8'h0, 8'h0);
    do_reset(1);
    wait_init();
    drive(1'b1, 1'b1, 2'b10, 12'h0, 8'h0F, 8'h0F);
    idle(3);

    // Randomised traffic over a few crowded nodes
    for (int i = 0; i < 500; i++) begin
      rn = 8'h10 + 8'($urandom_range(0, 3));
      rb = 8'h10 + 8'($urandom_range(0, 3));
      rt = {8'h10 + 8'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
      drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)), rt, rn, rb);
    end
    idle(5);

    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
